fairy_sram_bridge: RTL and testbench
====================================

Name: fairy_sram_bridge

Overview:
- Parametrised request/response bridge between a pipeline stage (fetch or mem) and one SRAM port (cen/wr/addr/wdata/ack/rrdy/rdata).
- Replaces the fixed always-ready SRAM assumption: honours ack/rrdy, holds requests until acked, tracks outstanding reads, buffers in-order read data, and cancels or drops in-flight reads on a pipeline flush (writeback exception).
- One instance per SRAM port; DEPTH bounds the outstanding reads plus buffered responses.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; multiple of 8. BE_W = DATA_W/8 is derived.
- DEPTH, 2, max reads pending (accepted but not yet popped or dropped); power of 2, >=1.

Ports:
- aclk  in  1  clock, rising edge.
- areset_n  in  1  asynchronous active-low reset.
- flush_i  in  1  cancel all younger traffic (exception).
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_wr_i  in  1  1=write, 0=read.
- req_be_i  in  BE_W  active-high byte enables.
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  DATA_W  write data.
- rsp_valid_o  out  1  read data available (FIFO head).
- rsp_ready_i  in  1  consumer pops head.
- rsp_rdata_o  out  DATA_W  read data.
- sram_cen_o  out  BE_W  active-low byte enables; all ones = idle.
- sram_wr_o  out  1  write strobe.
- sram_addr_o  out  ADDR_W  address.
- sram_wdata_o  out  DATA_W  write data.
- sram_ack_i  in  1  SRAM accepted the presented request this cycle.
- sram_rrdy_i  in  1  read data valid on sram_rdata_i, in order.
- sram_rdata_i  in  DATA_W  read data.
- pending_o  out  $clog2(DEPTH+1)  reads pending count (debug).
- protocol_err_o  out  1  sticky: rrdy with no read in flight.

Behaviour:
- Reset (async): hold register empty, sram_cen_o all ones, sram_wr_o 0, sram_addr_o 0, sram_wdata_o 0; FIFO empty, rsp_valid_o 0, rsp_rdata_o 0; pending, inflight and drop counters 0; protocol_err_o 0.
- Hold register, states IDLE/HOLD. Accepted request is loaded; SRAM outputs are driven from it in the next cycle (1-cycle request latency). cen = ~be, wr, addr and wdata stay stable until the cycle sram_ack_i=1. The register then empties, or reloads if a new request is accepted in the same cycle.
- In IDLE, sram_cen_o is all ones and sram_wr_o is 0; ack is ignored.
- req_ready_o = (IDLE | sram_ack_i) & !flush_i & (req_wr_i | pending < DEPTH). The ready path depends combinationally on ack and req_wr_i.
- Writes need no credit and produce no response.
- pending increments on read acceptance. It decrements on FIFO pop, on a dropped return, and on cancellation of an unacked held read.
- inflight (acked reads awaiting rrdy) increments on ack of a read and decrements on rrdy.
- Response FIFO has DEPTH entries. It is pushed on sram_rrdy_i when drop=0 and flush_i=0, and popped on rsp_valid_o & rsp_ready_i. Push and pop in the same cycle are allowed, including when full. Credit accounting guarantees no overflow. No combinational path from rrdy to rsp_valid_o: data is visible the cycle after rrdy.
- rrdy with drop>0 discards the data and decrements drop.
- flush_i, one cycle:
  - An unacked held request is cancelled, and cen returns to all ones next cycle.
  - A held request acked in the flush cycle counts as issued. A write is done; a read is added to drop.
  - FIFO is cleared.
  - drop := drop + inflight + (read acked this cycle) - (rrdy this cycle).
  - pending := new drop.
  - No request is accepted in the flush cycle.
- rrdy with inflight=0: data ignored, protocol_err_o set until reset.
- Counters never wrap: pending <= DEPTH and inflight <= pending by construction.
- Reset mid-transaction: all state is cleared immediately. Any SRAM returns after reset are flagged as protocol errors.

Test Plan:
- Single read, addr 0x100, be 4'hF: cen=4'h0 the next cycle. Ack is delayed 3 cycles, so addr is held 3 cycles. rrdy then returns 0xDEADBEEF. rsp_valid_o rises the cycle after rrdy with 0xDEADBEEF; pending goes 1 -> 0 on pop.
- Write, be 4'b0011, wdata 0x12345678, ack immediate: cen=4'b1100, wr=1 for exactly 1 cycle. No response; pending stays 0.
- DEPTH=2, three back-to-back reads with ack=1 and rsp_ready=0: the third stalls (req_ready=0). After 2 rrdy returns and one pop, the third is accepted. Responses arrive in order.
- Flush with 2 reads acked (inflight=2) and rrdy in the same cycle: drop=1. The next rrdy is discarded, rsp_valid stays 0, and pending reaches 0.
- Flush while a held read is unacked: cen goes all ones next cycle; pending 1 -> 0; no data pushed.
- rrdy asserted at idle after reset: protocol_err_o=1 and stays set; FIFO stays empty.

Source files
------------

// File: rtl/fairy_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : fairy_sram_bridge
// Purpose  : Request/response bridge between a pipeline stage (fetch or mem)
//            and a single SRAM port. Holds each request until the SRAM acks
//            it. Tracks outstanding reads and buffers in-order read data.
//            On a pipeline flush it cancels or drops in-flight reads.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   aclk, areset_n    clock (rising edge), asynchronous active-low reset
//   flush_i           cancel all younger traffic
//   req_*             request channel (valid/ready, wr, be, addr, wdata)
//   rsp_*             read response channel (valid/ready, rdata)
//   sram_cen_o        active-low byte enables, all ones = idle
//   sram_wr_o         write strobe
//   sram_addr_o       address
//   sram_wdata_o      write data
//   sram_ack_i        SRAM accepted the presented request
//   sram_rrdy_i       read data valid on sram_rdata_i, returned in order
//   sram_rdata_i      read data
//   pending_o         reads accepted but not yet popped or dropped
//   protocol_err_o    sticky flag: read data returned with no read outstanding
// ============================================================================
module fairy_sram_bridge #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic                           aclk,
   input  logic                           areset_n,
   input  logic                           flush_i,
   input  logic                           req_valid_i,
   output logic                           req_ready_o,
   input  logic                           req_wr_i,
   input  logic [DATA_W/8-1:0]            req_be_i,
   input  logic [ADDR_W-1:0]              req_addr_i,
   input  logic [DATA_W-1:0]              req_wdata_i,
   output logic                           rsp_valid_o,
   input  logic                           rsp_ready_i,
   output logic [DATA_W-1:0]              rsp_rdata_o,
   output logic [DATA_W/8-1:0]            sram_cen_o,
   output logic                           sram_wr_o,
   output logic [ADDR_W-1:0]              sram_addr_o,
   output logic [DATA_W-1:0]              sram_wdata_o,
   input  logic                           sram_ack_i,
   input  logic                           sram_rrdy_i,
   input  logic [DATA_W-1:0]              sram_rdata_i,
   output logic [$clog2(DEPTH+1)-1:0]     pending_o,
   output logic                           protocol_err_o
);

   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   // ------------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------------
   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_load;

   logic                  r_hold_wr;
   logic [BE_W-1:0]       r_hold_be;
   logic [ADDR_W-1:0]     r_hold_addr;
   logic [DATA_W-1:0]     r_hold_wdata;

   logic [CNT_W-1:0]      r_pending;
   logic [CNT_W-1:0]      r_inflight;
   logic [CNT_W-1:0]      r_drop;
   logic [CNT_W-1:0]      w_pending_nxt;
   logic [CNT_W-1:0]      w_inflight_nxt;
   logic [CNT_W-1:0]      w_drop_nxt;

   logic [DATA_W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [CNT_W-1:0]      r_count;

   logic                  r_proto_err;

   logic                  w_holding;
   logic                  w_ack;
   logic                  w_ack_rd;
   logic                  w_req_ready;
   logic                  w_accept;
   logic                  w_accept_rd;
   logic                  w_rrdy_drop;
   logic                  w_rrdy_live;
   logic                  w_rrdy_err;
   logic                  w_rsp_valid;
   logic                  w_pop;
   logic                  w_push;

   // ------------------------------------------------------------------------
   // Handshake decode
   // ------------------------------------------------------------------------
   assign w_holding   = (r_state == ST_HOLD);
   assign w_ack       = w_holding & sram_ack_i;
   assign w_ack_rd    = w_ack & ~r_hold_wr;

   // A read needs a credit; writes never produce a response so they do not.
   // Credits freed by a same-cycle pop are only visible next cycle.
   assign w_req_ready = (~w_holding | sram_ack_i) & ~flush_i &
                        (req_wr_i | (r_pending < c_depth));
   assign w_accept    = req_valid_i & w_req_ready;
   assign w_accept_rd = w_accept & ~req_wr_i;

   // Returns arrive in order. Reads dropped by an earlier flush are older
   // than anything still in flight, so they are consumed first.
   assign w_rrdy_drop = sram_rrdy_i & (r_drop != '0);
   assign w_rrdy_live = sram_rrdy_i & (r_drop == '0) & (r_inflight != '0);
   assign w_rrdy_err  = sram_rrdy_i & (r_drop == '0) & (r_inflight == '0);

   assign w_rsp_valid = (r_count != '0);
   assign w_pop       = w_rsp_valid & rsp_ready_i;
   assign w_push      = w_rrdy_live & ~flush_i;

   // ------------------------------------------------------------------------
   // Hold register FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      if (flush_i) begin
         // Unacked request is cancelled; an acked one has already issued.
         w_state_nxt = ST_IDLE;
      end else if (w_accept) begin
         w_state_nxt = ST_HOLD;
         w_load      = 1'b1;
      end else if (w_ack) begin
         w_state_nxt = ST_IDLE;
      end
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         r_hold_wr    <= 1'b0;
         r_hold_be    <= '0;
         r_hold_addr  <= '0;
         r_hold_wdata <= '0;
      end else if (w_load) begin
         r_hold_wr    <= req_wr_i;
         r_hold_be    <= req_be_i;
         r_hold_addr  <= req_addr_i;
         r_hold_wdata <= req_wdata_i;
      end
   end

   // ------------------------------------------------------------------------
   // Read accounting: pending (credits), inflight (acked, awaiting data),
   // drop (acked before a flush, data to be discarded)
   // ------------------------------------------------------------------------
   always_comb begin
      w_pending_nxt  = r_pending;
      w_inflight_nxt = r_inflight;
      w_drop_nxt     = r_drop;
      if (flush_i) begin
         // Everything already issued to the SRAM becomes droppable. Buffered
         // data and the cancelled held read vanish, so the pending count
         // collapses to what is still owed by the SRAM.
         w_drop_nxt     = r_drop + r_inflight + CNT_W'(w_ack_rd)
                          - CNT_W'(w_rrdy_drop | w_rrdy_live);
         w_inflight_nxt = '0;
         w_pending_nxt  = w_drop_nxt;
      end else begin
         w_drop_nxt     = r_drop - CNT_W'(w_rrdy_drop);
         w_inflight_nxt = r_inflight + CNT_W'(w_ack_rd) - CNT_W'(w_rrdy_live);
         w_pending_nxt  = r_pending + CNT_W'(w_accept_rd)
                          - CNT_W'(w_pop) - CNT_W'(w_rrdy_drop);
      end
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         r_pending   <= '0;
         r_inflight  <= '0;
         r_drop      <= '0;
         r_proto_err <= 1'b0;
      end else begin
         r_pending  <= w_pending_nxt;
         r_inflight <= w_inflight_nxt;
         r_drop     <= w_drop_nxt;
         if (w_rrdy_err) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Response FIFO. The credit scheme guarantees it never overflows, so a
   // push while full only happens together with a pop.
   // ------------------------------------------------------------------------
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
         end
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   // Storage needs no reset: the data output is gated by the valid flag.
   always_ff @(posedge aclk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= sram_rdata_i;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign req_ready_o    = w_req_ready;
   assign rsp_valid_o    = w_rsp_valid;
   assign rsp_rdata_o    = w_rsp_valid ? r_mem[r_rd_ptr] : '0;
   assign sram_cen_o     = w_holding ? ~r_hold_be : '1;
   assign sram_wr_o      = w_holding & r_hold_wr;
   assign sram_addr_o    = r_hold_addr;
   assign sram_wdata_o   = r_hold_wdata;
   assign pending_o      = r_pending;
   assign protocol_err_o = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_fairy_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_fairy_sram_bridge
// Purpose  : Self-checking bench for fairy_sram_bridge (DATA_W=32, DEPTH=2).
//            Table of single-request vectors plus hand-written sequences for
//            delayed ack, credit stall, flush and protocol-error cases.
//            Expected read data is queued when the SRAM return is driven and
//            compared when the response is popped.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fairy_sram_bridge;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 2;
   localparam int BE_W   = DATA_W / 8;

   logic                       aclk;
   logic                       areset_n;
   logic                       flush_i;
   logic                       req_valid;
   logic                       req_ready;
   logic                       req_wr;
   logic [BE_W-1:0]            req_be;
   logic [ADDR_W-1:0]          req_addr;
   logic [DATA_W-1:0]          req_wdata;
   logic                       rsp_valid;
   logic                       rsp_ready;
   logic [DATA_W-1:0]          rsp_rdata;
   logic [BE_W-1:0]            sram_cen;
   logic                       sram_wr;
   logic [ADDR_W-1:0]          sram_addr;
   logic [DATA_W-1:0]          sram_wdata;
   logic                       sram_ack;
   logic                       sram_rrdy;
   logic [DATA_W-1:0]          sram_rdata;
   logic [$clog2(DEPTH+1)-1:0] pending;
   logic                       protocol_err;

   fairy_sram_bridge #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .aclk           (aclk),
      .areset_n       (areset_n),
      .flush_i        (flush_i),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_wr_i       (req_wr),
      .req_be_i       (req_be),
      .req_addr_i     (req_addr),
      .req_wdata_i    (req_wdata),
      .rsp_valid_o    (rsp_valid),
      .rsp_ready_i    (rsp_ready),
      .rsp_rdata_o    (rsp_rdata),
      .sram_cen_o     (sram_cen),
      .sram_wr_o      (sram_wr),
      .sram_addr_o    (sram_addr),
      .sram_wdata_o   (sram_wdata),
      .sram_ack_i     (sram_ack),
      .sram_rrdy_i    (sram_rrdy),
      .sram_rdata_i   (sram_rdata),
      .pending_o      (pending),
      .protocol_err_o (protocol_err)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        wr;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [3:0]  exp_cen;
   } vec_t;

   vec_t         vecs [4];
   logic [31:0]  sb [$];
   int           n_total = 0;
   int           n_pass  = 0;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic pop_check(input string name);
      logic [31:0] e;
      rsp_ready = 1'b1;
      #1;
      chk({name, "_valid"}, {31'd0, rsp_valid}, 32'd1);
      if (sb.size() == 0) begin
         n_total++;
         $display("FAIL %s: got pop with rdata 0x%0h required empty scoreboard entry", name, rsp_rdata);
      end else begin
         e = sb.pop_front();
         chk(name, rsp_rdata, e);
      end
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic sram_return(input logic [31:0] data, input logic expect_rsp);
      sram_rrdy  = 1'b1;
      sram_rdata = data;
      if (expect_rsp) sb.push_back(data);
      tick();
      sram_rrdy  = 1'b0;
      sram_rdata = '0;
   endtask

   initial begin
      vecs[0] = '{wr: 1'b1, be: 4'b0011, addr: 32'h0000_0200, wdata: 32'h1234_5678,
                  rdata: 32'h0, exp_cen: 4'b1100};
      vecs[1] = '{wr: 1'b0, be: 4'b1111, addr: 32'h0000_0100, wdata: 32'h0,
                  rdata: 32'hDEAD_BEEF, exp_cen: 4'b0000};
      vecs[2] = '{wr: 1'b0, be: 4'b0101, addr: 32'h0000_0104, wdata: 32'h0,
                  rdata: 32'hCAFE_F00D, exp_cen: 4'b1010};
      vecs[3] = '{wr: 1'b1, be: 4'b1000, addr: 32'h0000_03FC, wdata: 32'hA5A5_A5A5,
                  rdata: 32'h0, exp_cen: 4'b0111};

      areset_n   = 1'b0;
      flush_i    = 1'b0;
      req_valid  = 1'b0;
      req_wr     = 1'b0;
      req_be     = '0;
      req_addr   = '0;
      req_wdata  = '0;
      rsp_ready  = 1'b0;
      sram_ack   = 1'b0;
      sram_rrdy  = 1'b0;
      sram_rdata = '0;

      // ---------------- reset state ----------------
      #12;
      chk("rst_cen",       {28'd0, sram_cen}, 32'hF);
      chk("rst_wr",        {31'd0, sram_wr}, 32'd0);
      chk("rst_addr",      sram_addr, 32'd0);
      chk("rst_wdata",     sram_wdata, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_pending",   {30'd0, pending}, 32'd0);
      chk("rst_perr",      {31'd0, protocol_err}, 32'd0);
      chk("rst_ready",     {31'd0, req_ready}, 32'd1);
      #10;
      areset_n = 1'b1;
      tick();

      // ---------------- table-driven single requests, immediate ack ----------------
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1;
         req_wr    = vecs[i].wr;
         req_be    = vecs[i].be;
         req_addr  = vecs[i].addr;
         req_wdata = vecs[i].wdata;
         #1;
         chk($sformatf("v%0d_ready", i), {31'd0, req_ready}, 32'd1);
         tick();
         req_valid = 1'b0;
         chk($sformatf("v%0d_cen", i),  {28'd0, sram_cen}, {28'd0, vecs[i].exp_cen});
         chk($sformatf("v%0d_wr", i),   {31'd0, sram_wr}, {31'd0, vecs[i].wr});
         chk($sformatf("v%0d_addr", i), sram_addr, vecs[i].addr);
         if (vecs[i].wr) chk($sformatf("v%0d_wdata", i), sram_wdata, vecs[i].wdata);
         chk($sformatf("v%0d_pend_held", i), {30'd0, pending}, vecs[i].wr ? 32'd0 : 32'd1);
         sram_ack = 1'b1;
         tick();
         sram_ack = 1'b0;
         chk($sformatf("v%0d_cen_idle", i), {28'd0, sram_cen}, 32'hF);
         chk($sformatf("v%0d_wr_idle", i),  {31'd0, sram_wr}, 32'd0);
         if (!vecs[i].wr) begin
            sram_return(vecs[i].rdata, 1'b1);
            pop_check($sformatf("v%0d_rdata", i));
         end else begin
            tick();
         end
         chk($sformatf("v%0d_rsp_empty", i), {31'd0, rsp_valid}, 32'd0);
         chk($sformatf("v%0d_pend_end", i),  {30'd0, pending}, 32'd0);
      end

      // ---------------- read with ack delayed three cycles ----------------
      req_valid = 1'b1; req_wr = 1'b0; req_be = 4'hF; req_addr = 32'h100;
      tick();
      req_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("dly_cen%0d", k),  {28'd0, sram_cen}, 32'h0);
         chk($sformatf("dly_addr%0d", k), sram_addr, 32'h100);
         tick();
      end
      sram_ack = 1'b1;
      tick();
      sram_ack = 1'b0;
      chk("dly_cen_after_ack", {28'd0, sram_cen}, 32'hF);
      chk("dly_no_rsp_yet",    {31'd0, rsp_valid}, 32'd0);
      sram_rrdy = 1'b1; sram_rdata = 32'hDEAD_BEEF;
      #1;
      chk("dly_no_comb_rsp",   {31'd0, rsp_valid}, 32'd0);
      sb.push_back(32'hDEAD_BEEF);
      tick();
      sram_rrdy = 1'b0; sram_rdata = '0;
      chk("dly_pend_before_pop", {30'd0, pending}, 32'd1);
      pop_check("dly_rdata");
      chk("dly_pend_after_pop",  {30'd0, pending}, 32'd0);

      // ---------------- credit stall with DEPTH=2 ----------------
      sram_ack = 1'b1;
      req_valid = 1'b1; req_wr = 1'b0; req_be = 4'hF; req_addr = 32'h400;
      tick();                                  // r0 accepted
      req_addr = 32'h404;
      #1;
      chk("stall_ready_r1", {31'd0, req_ready}, 32'd1);
      tick();                                  // r1 accepted, r0 acked
      req_addr = 32'h408;
      #1;
      chk("stall_ready_r2", {31'd0, req_ready}, 32'd0);
      tick();                                  // r1 acked
      sram_ack = 1'b0;
      #1;
      chk("stall_ready_idle", {31'd0, req_ready}, 32'd0);
      chk("stall_pending2",   {30'd0, pending}, 32'd2);
      sram_return(32'h1111_0000, 1'b1);
      sram_return(32'h2222_0000, 1'b1);
      chk("stall_ready_full", {31'd0, req_ready}, 32'd0);
      pop_check("stall_rd0");
      #1;
      chk("stall_ready_freed", {31'd0, req_ready}, 32'd1);
      tick();                                  // r2 accepted
      req_valid = 1'b0;
      chk("stall_r2_addr", sram_addr, 32'h408);
      sram_ack = 1'b1;
      tick();
      sram_ack = 1'b0;
      sram_return(32'h3333_0000, 1'b1);
      pop_check("stall_rd1");
      pop_check("stall_rd2");
      chk("stall_pend_end", {30'd0, pending}, 32'd0);

      // ---------------- flush with two reads in flight and rrdy ----------------
      sram_ack = 1'b1;
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h500;
      tick();
      req_addr = 32'h504;
      tick();
      req_valid = 1'b0;
      tick();                                  // second read acked
      sram_ack = 1'b0;
      flush_i = 1'b1;
      sram_rrdy = 1'b1; sram_rdata = 32'hBAD0_0001;
      #1;
      chk("fl_ready_in_flush", {31'd0, req_ready}, 32'd0);
      tick();
      flush_i = 1'b0;
      sram_rrdy = 1'b0;
      chk("fl_pend_is_drop", {30'd0, pending}, 32'd1);
      chk("fl_rsp_cleared",  {31'd0, rsp_valid}, 32'd0);
      sram_return(32'hBAD0_0002, 1'b0);
      chk("fl_drop_rsp",     {31'd0, rsp_valid}, 32'd0);
      chk("fl_drop_pend",    {30'd0, pending}, 32'd0);
      chk("fl_drop_noerr",   {31'd0, protocol_err}, 32'd0);

      // ---------------- flush cancels an unacked held read ----------------
      req_valid = 1'b1; req_wr = 1'b0; req_be = 4'hF; req_addr = 32'h600;
      tick();
      req_valid = 1'b0;
      chk("cx_cen_held", {28'd0, sram_cen}, 32'h0);
      chk("cx_pend1",    {30'd0, pending}, 32'd1);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("cx_cen_idle", {28'd0, sram_cen}, 32'hF);
      chk("cx_pend0",    {30'd0, pending}, 32'd0);
      tick();
      chk("cx_no_rsp",   {31'd0, rsp_valid}, 32'd0);

      // ---------------- reset mid-stream, then stray rrdy ----------------
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h700;
      tick();
      req_valid = 1'b0;
      #2;
      areset_n = 1'b0;
      #1;
      chk("mr_cen_async", {28'd0, sram_cen}, 32'hF);
      chk("mr_pend_async", {30'd0, pending}, 32'd0);
      #3;
      areset_n = 1'b1;
      tick();
      sram_return(32'hFFFF_0000, 1'b0);
      chk("perr_set",    {31'd0, protocol_err}, 32'd1);
      chk("perr_no_rsp", {31'd0, rsp_valid}, 32'd0);
      tick();
      tick();
      chk("perr_sticky", {31'd0, protocol_err}, 32'd1);
      chk("sb_drained",  sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
